// File: rtl/seq_muldiv.sv
// Iterative signed/unsigned multiply/divide unit producing HI/LO results.
// One result bit per cycle: shift-add for multiply, restoring division for divide.
module seq_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t             state, state_next;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic               res_neg, rem_neg;
    logic [CW-1:0]      count;

    logic               is_signed, is_div, last_step;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;

    assign is_signed = op_r[0];
    assign is_div    = op_r[1];
    assign last_step = (count == CW'(WIDTH - 1));

    always_comb begin
        abs_a = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
        abs_b = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
    end

    // acc holds {upper, lower}: for multiply {partial product, multiplier},
    // for divide {partial remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b};
        acc_step  = acc;
        if (is_div) begin
            if (!rem_diff[WIDTH])
                acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_step = {add_sum, acc[WIDTH-1:1]};
            else
                acc_step = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = res_neg ? -acc : acc;
        quo  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = PREP;
            PREP: begin
                busy       = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (last_step) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    a_r  <= a;
                    b_r  <= b;
                end
                PREP: begin
                    mag_a   <= abs_a;
                    mag_b   <= abs_b;
                    res_neg <= is_signed & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    rem_neg <= is_signed & a_r[WIDTH-1];
                    acc     <= is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    count   <= '0;
                end
                ITER: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (!is_div) begin
                        hi          <= prod[2*WIDTH-1:WIDTH];
                        lo          <= prod[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end else if (b_r == '0) begin
                        hi          <= a_r;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi          <= rem;
                        lo          <= quo;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv: vector table on 32- and 8-bit instances
// plus hand-written abort, ignored-start and back-to-back sequences.
module tb_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sel8;
    logic [1:0]  op;
    logic [31:0] a, b;

    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        start32, start8;
    logic        busy_m, done_m, dbz_m;
    logic [31:0] hi_m, lo_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign start32 = start & ~sel8;
    assign start8  = start & sel8;

    seq_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_by_zero(dbz32)
    );

    seq_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8)
    );

    always_comb begin
        busy_m = sel8 ? busy8 : busy32;
        done_m = sel8 ? done8 : done32;
        dbz_m  = sel8 ? dbz8  : dbz32;
        hi_m   = sel8 ? {24'h0, hi8} : hi32;
        lo_m   = sel8 ? {24'h0, lo8} : lo32;
    end

    typedef struct {
        bit          narrow;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then check latency, busy length, results and the hold after done.
    task automatic run_op(input vec_t v, input bit disturb);
        int  n, busy_cnt, w;
        bit  got;
        w = v.narrow ? 8 : 32;
        sel8 = v.narrow;
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        tick();
        start = 1'b0;
        n = 0; busy_cnt = 0; got = 1'b0;
        while (!got && n < 200) begin
            if (disturb && n == 5) begin
                start = 1'b1; op = 2'b10; a = 32'h7; b = 32'h9;
            end
            if (disturb && n == 6) start = 1'b0;
            if (busy_m) busy_cnt++;
            if (done_m) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        check("latency", 64'(n), 64'(w + 2));
        check("busy_cycles", 64'(busy_cnt), 64'(w + 2));
        check("hi", 64'(hi_m), 64'(v.hi));
        check("lo", 64'(lo_m), 64'(v.lo));
        check("div_by_zero", 64'(dbz_m), 64'(v.dbz));
        tick();
        check("done_width", 64'(done_m), 64'd0);
        check("hi_hold", 64'(hi_m), 64'(v.hi));
        check("lo_hold", 64'(lo_m), 64'(v.lo));
    endtask

    // start held high: done must recur every w+4 cycles, one cycle wide.
    task automatic run_continuous(input bit narrow, input logic [31:0] ea, input logic [31:0] eb,
                                  input logic [31:0] exp_lo);
        int n, pulses, w, exp_pos;
        bit prev_done;
        w = narrow ? 8 : 32;
        sel8 = narrow;
        start = 1'b1; op = 2'b00; a = ea; b = eb;
        tick();
        n = 0; pulses = 0; prev_done = 1'b0;
        while (pulses < 3 && n < 4 * (w + 4) + 10) begin
            if (prev_done) check("cont_done_width", 64'(done_m), 64'd0);
            if (pulses > 0) begin
                check("cont_hi_stable", 64'(hi_m), 64'd0);
                check("cont_lo_stable", 64'(lo_m), 64'(exp_lo));
            end
            prev_done = done_m;
            if (done_m) begin
                exp_pos = (w + 2) + pulses * (w + 4);
                check("cont_done_pos", 64'(n), 64'(exp_pos));
                check("cont_lo", 64'(lo_m), 64'(exp_lo));
                check("cont_hi", 64'(hi_m), 64'd0);
                pulses++;
            end
            if (pulses < 3) begin
                tick();
                n++;
            end
        end
        start = 1'b0;
        check("cont_pulses", 64'(pulses), 64'd3);
        tick();
        check("cont_done_width", 64'(done_m), 64'd0);
        tick();
    endtask

    initial begin
        int  n;
        bit  seen;
        vec_t v;

        vecs[0]  = '{1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{1'b0, 2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{1'b0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[9]  = '{1'b0, 2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[12] = '{1'b1, 2'b01, 32'h80,       32'h80,       32'h40,       32'h00,       1'b0};
        vecs[13] = '{1'b1, 2'b10, 32'd200,      32'd9,        32'd2,        32'd22,       1'b0};
        vecs[14] = '{1'b1, 2'b11, 32'hF9,       32'h02,       32'hFF,       32'hFD,       1'b0};

        rst = 1'b1; start = 1'b0; sel8 = 1'b0; op = 2'b00; a = '0; b = '0;
        tick();
        tick();
        check("rst_busy", 64'(busy32 | busy8), 64'd0);
        check("rst_done", 64'(done32 | done8), 64'd0);
        check("rst_hi_lo", {hi32, lo32}, 64'd0);
        check("rst_dbz", 64'(dbz32 | dbz8), 64'd0);
        check("rst_hi_lo8", 64'({hi8, lo8}), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) run_op(vecs[i], 1'b0);

        // start pulse and operand changes during ITER must not affect the running op
        v = '{1'b0, 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0};
        run_op(v, 1'b1);

        // reset mid-operation: outputs clear immediately, no done afterwards
        v = '{1'b0, 2'b00, 32'hFFFF0000, 32'h00010000, 32'h0000FFFF, 32'h00000000, 1'b0};
        run_op(v, 1'b0);
        sel8 = 1'b0;
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start = 1'b1; a = 32'd11; b = 32'd13;
            end
            if (i == 5) start = 1'b0;
            tick();
        end
        check("abort_busy_pre", 64'(busy32), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_hi_lo", {hi32, lo32}, 64'd0);
        check("abort_done", 64'(done32), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done32) seen = 1'b1;
            tick();
        end
        check("abort_no_done", 64'(seen), 64'd0);
        v = '{1'b0, 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0};
        run_op(v, 1'b0);

        run_continuous(1'b0, 32'd3, 32'd4, 32'd12);
        run_continuous(1'b1, 32'd3, 32'd4, 32'd12);
        v = '{1'b1, 2'b01, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0};
        run_op(v, 1'b0);

        n = n_checks;
        if (n < 12) begin
            n_fail++;
            $display("FAIL check_count: got %0d, expected at least 12", n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
